// File: rtl/ddr2_traffic_gen_if.sv
// ============================================================================
// Module  : ddr2_traffic_gen_if
// Brief   : Application-side bundle between the DDR2 traffic generator and
//           the memory controller user interface.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ddr2_traffic_gen_if #(
   parameter int DQ_WIDTH = 72,
   parameter int DM_WIDTH = 9
);
   logic                    init_done;
   logic                    wdf_almost_full;
   logic                    af_almost_full;
   logic [1:0]              mode;
   logic [2:0]              burst_length_div2;
   logic                    read_data_valid;
   logic [2*DQ_WIDTH-1:0]   read_data_fifo_out;
   logic [35:0]             app_af_addr;
   logic                    app_af_wren;
   logic [2*DQ_WIDTH-1:0]   app_wdf_data;
   logic [2*DM_WIDTH-1:0]   app_mask_data;
   logic                    app_wdf_wren;
   logic                    error;
   logic [15:0]             error_count;
   logic [15:0]             pass_count;

   modport master (
      input  init_done, wdf_almost_full, af_almost_full, mode,
             burst_length_div2, read_data_valid, read_data_fifo_out,
      output app_af_addr, app_af_wren, app_wdf_data, app_mask_data,
             app_wdf_wren, error, error_count, pass_count
   );

   modport slave (
      output init_done, wdf_almost_full, af_almost_full, mode,
             burst_length_div2, read_data_valid, read_data_fifo_out,
      input  app_af_addr, app_af_wren, app_wdf_data, app_mask_data,
             app_wdf_wren, error, error_count, pass_count
   );
endinterface

`default_nettype wire

// File: rtl/ddr2_traffic_gen.sv
// ============================================================================
// Module  : ddr2_traffic_gen
// Brief   : Write/read pattern generator with read-back compare for DDR2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ddr2_traffic_gen #(
   parameter int          DQ_WIDTH         = 72,
   parameter int          DM_WIDTH         = 9,
   parameter int          BURSTS_PER_PHASE = 8,
   parameter logic [31:0] ADDR_BASE        = 32'h0,
   parameter int          ADDR_STRIDE      = 4,
   parameter int          ADDR_WRAP        = 256
) (
   input  wire logic           clk,
   input  wire logic           reset,
   ddr2_traffic_gen_if.master  bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

   localparam logic [15:0] c_idx_last = 16'(ADDR_WRAP - 1);
   localparam logic [7:0]  c_cmd_last = 8'(BURSTS_PER_PHASE - 1);

   state_t      r_state, w_next;
   logic        r_wdf_af;
   logic [15:0] r_idx, r_phase_idx, r_cmp_idx;
   logic [2:0]  r_beat, r_bl, r_cmp_beat, r_cmp_bl;
   logic [7:0]  r_cmd_cnt;

   logic        w_go_wr, w_go_rd, w_wr_cmd, w_cmd, w_phase_end;
   logic        w_start, w_replay, w_mismatch;
   logic [2:0]  w_bl_in;
   logic [15:0] w_idx_inc;
   logic [31:0] w_addr;

   // Rise half occupies the low DQ_WIDTH bits, fall half the high bits.
   function automatic logic [2*DQ_WIDTH-1:0] pattern(input logic [15:0] idx,
                                                     input logic [2:0]  beat);
      logic [7:0] v;
      v = idx[7:0] + {5'd0, beat};
      return {{(DQ_WIDTH/8){~v}}, {(DQ_WIDTH/8){v}}};
   endfunction

   assign bus.app_mask_data = {(2*DM_WIDTH){1'b0}};

   always_comb begin
      w_bl_in     = (bus.burst_length_div2 == 3'd0 || bus.burst_length_div2 > 3'd4)
                    ? 3'd4 : bus.burst_length_div2;
      w_go_wr     = (r_state == WRITE) && !r_wdf_af && !bus.af_almost_full;
      w_go_rd     = (r_state == READ) && !bus.af_almost_full;
      w_wr_cmd    = w_go_wr && (r_beat == r_bl - 3'd1);
      w_cmd       = w_wr_cmd || w_go_rd;
      w_phase_end = w_cmd && (r_cmd_cnt == c_cmd_last);
      w_idx_inc   = (r_idx == c_idx_last) ? 16'd0 : r_idx + 16'd1;
      w_addr      = ADDR_BASE + {16'd0, r_idx} * 32'(ADDR_STRIDE);
      w_mismatch  = bus.read_data_valid &&
                    (bus.read_data_fifo_out != pattern(r_cmp_idx, r_cmp_beat));
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (bus.init_done && !r_wdf_af && !bus.af_almost_full) begin
               case (bus.mode)
                  2'b00, 2'b01: w_next = WRITE;
                  2'b10:        w_next = READ;
                  default:      w_next = IDLE;
               endcase
            end
         end
         WRITE, READ: begin
            if (w_phase_end) begin
               case (bus.mode)
                  2'b00:   w_next = (r_state == WRITE) ? READ : WRITE;
                  2'b01:   w_next = WRITE;
                  2'b10:   w_next = READ;
                  default: w_next = IDLE;
               endcase
            end
         end
         default: w_next = IDLE;
      endcase
      w_start  = (w_next != IDLE) && ((r_state == IDLE) || w_phase_end);
      // Loop mode reads back exactly the bursts the write phase just produced.
      w_replay = w_phase_end && (r_state == WRITE) && (w_next == READ) &&
                 (bus.mode == 2'b00);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= IDLE;
         r_wdf_af         <= 1'b0;
         r_idx            <= '0;
         r_phase_idx      <= '0;
         r_cmp_idx        <= '0;
         r_beat           <= '0;
         r_bl             <= '0;
         r_cmp_beat       <= '0;
         r_cmp_bl         <= '0;
         r_cmd_cnt        <= '0;
         bus.app_af_addr  <= '0;
         bus.app_af_wren  <= 1'b0;
         bus.app_wdf_data <= '0;
         bus.app_wdf_wren <= 1'b0;
         bus.error        <= 1'b0;
         bus.error_count  <= '0;
         bus.pass_count   <= '0;
      end else begin
         r_state          <= w_next;
         r_wdf_af         <= bus.wdf_almost_full;
         bus.app_af_wren  <= w_cmd;
         bus.app_wdf_wren <= w_go_wr;
         if (w_go_wr) begin
            bus.app_wdf_data <= pattern(r_idx, r_beat);
            r_beat           <= w_wr_cmd ? 3'd0 : r_beat + 3'd1;
         end
         if (w_cmd) begin
            bus.app_af_addr <= {1'b0, (r_state == READ) ? 3'b101 : 3'b100, w_addr};
            r_cmd_cnt       <= w_phase_end ? 8'd0 : r_cmd_cnt + 8'd1;
         end
         if (w_replay)
            r_idx <= r_phase_idx;
         else if (w_cmd)
            r_idx <= w_idx_inc;
         if (w_start) begin
            r_bl <= w_bl_in;
            if (w_next == WRITE)
               r_phase_idx <= w_cmd ? w_idx_inc : r_idx;
            if (w_next == READ)
               r_cmp_bl <= w_bl_in;
         end
         if (w_go_rd && w_phase_end)
            bus.pass_count <= bus.pass_count + 16'd1;
         if (bus.read_data_valid) begin
            if (r_cmp_beat == r_cmp_bl - 3'd1) begin
               r_cmp_beat <= 3'd0;
               r_cmp_idx  <= (r_cmp_idx == c_idx_last) ? 16'd0 : r_cmp_idx + 16'd1;
            end else begin
               r_cmp_beat <= r_cmp_beat + 3'd1;
            end
         end
         if (w_mismatch) begin
            bus.error <= 1'b1;
            if (bus.error_count != 16'hFFFF)
               bus.error_count <= bus.error_count + 16'd1;
         end
      end
   end

endmodule

`default_nettype wire
